wsn_data_aggregator: RTL and testbench

- Downstream of the sink-detection stage; launched when that stage flags the node for aggregation (its forAggregation output drives our start).
- Reads a child-packet count and N 16-bit sensor words from the shared node memory.
- Computes saturating sum, maximum and minimum, writes the three results back to fixed result addresses, then pulses done.
- Uses the same single-port synchronous memory interface as the sink-detection stage.

---
 rtl/wsn_agg_pkg.sv | 39 +++
 rtl/wsn_agg_divider.sv | 99 +++++++++
 rtl/wsn_data_aggregator.sv | 279 +++++++++++++++++++++++++++
 tb/tb_wsn_data_aggregator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wsn_agg_pkg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// wsn_agg_pkg
// Shared types and constants for the WSN data aggregator slice.
//   agg_state_e    : aggregator FSM state encoding
//   DEF_CNT_ADDR   : default address of the child-packet count word
//   DEF_DATA_BASE  : default address of the first sensor word
//   DEF_RES_ADDR   : default address of the sum result (max/min/avg follow)
//   *_OFS          : result word offsets from the result base address
//   DIV_W          : operand width of the serial averaging divider
// ---------------------------------------------------------------------------
package wsn_agg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CNT,
        S_LAT_CNT,
        S_RD_DAT,
        S_ACC,
        S_WR_SUM,
        S_WR_MAX,
        S_WR_MIN,
        S_DIV,
        S_WR_AVG,
        S_DONE
    } agg_state_e;

    localparam logic [10:0] DEF_CNT_ADDR  = 11'd8;
    localparam logic [10:0] DEF_DATA_BASE = 11'd16;
    localparam logic [10:0] DEF_RES_ADDR  = 11'd4;

    localparam int SUM_OFS = 0;
    localparam int MAX_OFS = 1;
    localparam int MIN_OFS = 2;
    localparam int AVG_OFS = 3;

    localparam int DIV_W = 16;

endpackage

// File: rtl/wsn_agg_divider.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// wsn_agg_divider
// Serial unsigned restoring divider, one quotient bit per enabled clock.
// A start pulse loads the operands; W enabled cycles later done pulses for
// one cycle and quotient holds the truncated result until the next start.
// Ports:
//   clock     in   system clock, rising edge
//   nrst      in   asynchronous active-low reset
//   en        in   clock-enable; low freezes the divider
//   start     in   load operands and begin dividing
//   dividend  in   W-bit unsigned dividend
//   divisor   in   W-bit unsigned divisor (caller guarantees non-zero)
//   quotient  out  W-bit quotient, valid from done onwards
//   done      out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module wsn_agg_divider
    import wsn_agg_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clock,
    input  logic         nrst,
    input  logic         en,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [W:0]       rem_shift;
    logic [W:0]       rem_sub;

    // One restoring step per cycle: shift the next dividend bit into the
    // partial remainder, subtract the divisor if it fits, and shift the
    // resulting quotient bit into the bottom of the dividend register.
    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        done_d    = 1'b0;
        rem_shift = {rem_q, quo_q[W-1]};
        rem_sub   = rem_shift - {1'b0, dvs_q};
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CNT_W'(W);
            run_d = 1'b1;
        end else if (run_q) begin
            if (rem_shift >= {1'b0, dvs_q}) begin
                rem_d = rem_sub[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state only advances while the shared clock-enable is high.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else if (en) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;

endmodule

// File: rtl/wsn_data_aggregator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// wsn_data_aggregator
// Reads a child-packet count and that many 16-bit sensor words from the
// shared single-port node memory, then writes back the saturating sum, the
// maximum and the minimum to fixed result addresses and pulses done.
// Optional feature macro WSN_AGG_AVG_EN: adds a serial divider and an extra
// write of the truncated average sum/n to the result base + 3.
// Ports:
//   clock     in   system clock, rising edge
//   nrst      in   asynchronous active-low reset
//   en        in   clock-enable; low freezes all state and outputs
//   start     in   launch request, sampled in idle
//   data_in   in   memory read data, valid one cycle after address
//   address   out  memory address (registered)
//   wr_en     out  memory write strobe (registered)
//   data_out  out  memory write data (registered)
//   busy      out  high from start accept through the done cycle
//   empty     out  last operation saw a zero count (held until next start)
//   ovf       out  sum saturated during last operation (held until next start)
//   done      out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module wsn_data_aggregator
    import wsn_agg_pkg::*;
#(
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 16,
    parameter logic [ADDR_W-1:0] CNT_ADDR  = DEF_CNT_ADDR,
    parameter logic [ADDR_W-1:0] DATA_BASE = DEF_DATA_BASE,
    parameter logic [ADDR_W-1:0] RES_ADDR  = DEF_RES_ADDR,
    parameter int                MAX_CNT   = 64
) (
    input  logic              clock,
    input  logic              nrst,
    input  logic              en,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] address,
    output logic              wr_en,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              empty,
    output logic              ovf,
    output logic              done
);

    // The last sensor word address must stay inside the address space.
    localparam longint LAST_DATA_ADDR = longint'(DATA_BASE) + longint'(MAX_CNT) - 1;
    localparam bit     PARAMS_OK      = (MAX_CNT > 0) && (LAST_DATA_ADDR < (longint'(1) << ADDR_W));

    if (!PARAMS_OK) begin : g_bad_params
        $error("wsn_data_aggregator: DATA_BASE + MAX_CNT - 1 wraps the address space");
    end

    localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

    agg_state_e        state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              busy_q, busy_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [DATA_W-1:0] min_q, min_d;

    logic [ADDR_W-1:0] n_clamped;
    logic [DATA_W:0]   sum_wide;
    logic              sat;
    logic [DATA_W-1:0] sum_acc;
    logic [DATA_W-1:0] max_acc;
    logic [DATA_W-1:0] min_acc;

`ifdef WSN_AGG_AVG_EN
    logic              div_start;
    logic              div_done;
    logic [DATA_W-1:0] div_quo;

    // The divide is kicked off while the max word is being written so that
    // its sixteen steps finish exactly as the DIV wait state ends; sum and
    // n are already final at that point. A zero count never starts it.
    assign div_start = (state_q == S_WR_MAX) && (n_q != '0);

    wsn_agg_divider #(
        .W (DATA_W)
    ) u_divider (
        .clock    (clock),
        .nrst     (nrst),
        .en       (en),
        .start    (div_start),
        .dividend (sum_q),
        .divisor  (DATA_W'(n_q)),
        .quotient (div_quo),
        .done     (div_done)
    );
`endif

    // Datapath helpers: clamp the incoming count, and fold the word
    // currently on data_in into the running saturating sum, max and min.
    // Ties in the compares leave the existing extreme in place.
    always_comb begin
        n_clamped = (data_in > DATA_W'(MAX_CNT)) ? ADDR_W'(MAX_CNT) : ADDR_W'(data_in);
        sum_wide  = {1'b0, sum_q} + {1'b0, data_in};
        sat       = sum_wide[DATA_W];
        sum_acc   = sat ? '1 : sum_wide[DATA_W-1:0];
        max_acc   = (data_in > max_q) ? data_in : max_q;
        min_acc   = (data_in < min_q) ? data_in : min_q;
    end

    // Next-state logic. Memory-facing outputs are loaded on the transition
    // into a state, so address/wr_en/data_out are valid for the whole cycle
    // that the state occupies. A write strobe lasts one state only.
    always_comb begin
        state_d    = state_q;
        address_d  = address_q;
        wr_en_d    = 1'b0;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        empty_d    = empty_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        n_d        = n_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        max_d      = max_q;
        min_d      = min_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RD_CNT;
                    address_d = CNT_ADDR;
                    busy_d    = 1'b1;
                    empty_d   = 1'b0;
                    ovf_d     = 1'b0;
                end
            end
            S_RD_CNT: begin
                state_d = S_LAT_CNT;
                sum_d   = '0;
                max_d   = '0;
                min_d   = '1;
                idx_d   = '0;
            end
            S_LAT_CNT: begin
                n_d = n_clamped;
                if (n_clamped == '0) begin
                    // Nothing to aggregate: every result is written as zero.
                    empty_d    = 1'b1;
                    min_d      = '0;
                    state_d    = S_WR_SUM;
                    address_d  = RES_ADDR + ADDR_W'(SUM_OFS);
                    data_out_d = '0;
                    wr_en_d    = 1'b1;
                end else begin
                    state_d   = S_RD_DAT;
                    address_d = DATA_BASE + idx_q;
                end
            end
            S_RD_DAT: begin
                state_d = S_ACC;
            end
            S_ACC: begin
                sum_d = sum_acc;
                max_d = max_acc;
                min_d = min_acc;
                idx_d = idx_q + ONE_A;
                if (sat) begin
                    ovf_d = 1'b1;
                end
                if (idx_q == n_q - ONE_A) begin
                    state_d    = S_WR_SUM;
                    address_d  = RES_ADDR + ADDR_W'(SUM_OFS);
                    data_out_d = sum_acc;
                    wr_en_d    = 1'b1;
                end else begin
                    state_d   = S_RD_DAT;
                    address_d = DATA_BASE + idx_q + ONE_A;
                end
            end
            S_WR_SUM: begin
                state_d    = S_WR_MAX;
                address_d  = RES_ADDR + ADDR_W'(MAX_OFS);
                data_out_d = max_q;
                wr_en_d    = 1'b1;
            end
            S_WR_MAX: begin
                state_d    = S_WR_MIN;
                address_d  = RES_ADDR + ADDR_W'(MIN_OFS);
                data_out_d = min_q;
                wr_en_d    = 1'b1;
            end
            S_WR_MIN: begin
`ifdef WSN_AGG_AVG_EN
                if (n_q == '0) begin
                    state_d    = S_WR_AVG;
                    address_d  = RES_ADDR + ADDR_W'(AVG_OFS);
                    data_out_d = '0;
                    wr_en_d    = 1'b1;
                end else begin
                    state_d = S_DIV;
                end
`else
                state_d = S_DONE;
                done_d  = 1'b1;
`endif
            end
`ifdef WSN_AGG_AVG_EN
            S_DIV: begin
                if (div_done) begin
                    state_d    = S_WR_AVG;
                    address_d  = RES_ADDR + ADDR_W'(AVG_OFS);
                    data_out_d = div_quo;
                    wr_en_d    = 1'b1;
                end
            end
            S_WR_AVG: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // All state and registered outputs; a low enable holds everything,
    // including an asserted write strobe.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            address_q  <= '0;
            wr_en_q    <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            empty_q    <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            n_q        <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            max_q      <= '0;
            min_q      <= '0;
        end else if (en) begin
            state_q    <= state_d;
            address_q  <= address_d;
            wr_en_q    <= wr_en_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            max_q      <= max_d;
            min_q      <= min_d;
        end
    end

    assign address  = address_q;
    assign wr_en    = wr_en_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign empty    = empty_q;
    assign ovf      = ovf_q;
    assign done     = done_q;

endmodule

// File: tb/tb_wsn_data_aggregator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_wsn_data_aggregator
// Directed bench for wsn_data_aggregator with a behavioural single-port
// memory. Expected values are hand-computed constants; the optional
// averaging feature (WSN_AGG_AVG_EN) shifts completion timing and adds a
// fourth result word.
// ---------------------------------------------------------------------------
module tb_wsn_data_aggregator;

`ifdef WSN_AGG_AVG_EN
    localparam int EXTRA      = 17;
    localparam int ZERO_DONE  = 7;
    localparam bit AVG_ON     = 1'b1;
`else
    localparam int EXTRA      = 0;
    localparam int ZERO_DONE  = 6;
    localparam bit AVG_ON     = 1'b0;
`endif

    logic        clock   = 1'b0;
    logic        nrst    = 1'b0;
    logic        en      = 1'b0;
    logic        start   = 1'b0;
    logic [15:0] data_in = '0;
    logic [10:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic        busy;
    logic        empty;
    logic        ovf;
    logic        done;

    logic [15:0] img [0:2047];
    logic [15:0] res_val [0:3];
    int          res_cnt [0:3];
    int          stray_wr;
    bit          touched [0:2047];
    logic        clr_log = 1'b0;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int sum_cyc;
    int tcount;

    wsn_data_aggregator dut (
        .clock    (clock),
        .nrst     (nrst),
        .en       (en),
        .start    (start),
        .data_in  (data_in),
        .address  (address),
        .wr_en    (wr_en),
        .data_out (data_out),
        .busy     (busy),
        .empty    (empty),
        .ovf      (ovf),
        .done     (done)
    );

    always #5 clock = ~clock;

    // Behavioural node memory: reads come from the preloaded image one
    // cycle after the address, writes to the result words are logged, and
    // every data-region address the DUT presents is remembered.
    always @(posedge clock) begin
        if (clr_log) begin
            for (int i = 0; i < 4; i++) begin
                res_val[i] = 16'hDEAD;
                res_cnt[i] = 0;
            end
            stray_wr = 0;
            for (int i = 0; i < 2048; i++) touched[i] = 1'b0;
        end else if (en) begin
            data_in <= img[address];
            if (wr_en) begin
                if (address >= 11'd4 && address <= 11'd7) begin
                    res_val[int'(address) - 4] = data_out;
                    res_cnt[int'(address) - 4]++;
                end else begin
                    stray_wr++;
                end
            end
            if (address >= 11'd16) touched[address] = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load the count word and the first three sensor words, then clear the
    // write log.
    task automatic applyStimulus(input logic [15:0] cnt, input logic [15:0] d0,
                                 input logic [15:0] d1, input logic [15:0] d2);
        for (int i = 0; i < 2048; i++) img[i] = 16'h1111;
        img[8]  = cnt;
        img[16] = d0;
        img[17] = d1;
        img[18] = d2;
        @(negedge clock);
        clr_log = 1'b1;
        @(negedge clock);
        clr_log = 1'b0;
    endtask

    // Launch one operation and count cycles until done. Cycle 0 is the one
    // in which start is accepted. Optionally freezes en for 5 cycles at a
    // given cycle and pulses start while busy.
    task automatic runOp(input int exp_done, input int freeze_at, input bit pulses,
                         input string tag, output int wsum_cyc);
        int cyc;
        wsum_cyc = -1;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 1000) begin
            @(negedge clock);
            cyc++;
            start = pulses && (cyc == 20 || cyc == 50);
            if (cyc == freeze_at) begin
                en = 1'b0;
                repeat (5) @(negedge clock);
                cyc += 5;
                checkOutput({tag, "_frz_addr"}, 32'(address), 32'd16);
                checkOutput({tag, "_frz_busy"}, 32'(busy), 32'd1);
                checkOutput({tag, "_frz_wr"}, 32'(wr_en), 32'd0);
                en = 1'b1;
            end
            if (wsum_cyc < 0 && wr_en === 1'b1 && address === 11'd4) wsum_cyc = cyc;
        end
        start = 1'b0;
        checkOutput({tag, "_done_cyc"}, 32'(cyc), 32'(exp_done));
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) img[i] = 16'h1111;
        en = 1'b1;
        repeat (2) @(negedge clock);

        // Reset state
        checkOutput("rst_address", 32'(address), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        nrst = 1'b1;

        // Count 3: {5, 200, 17}
        applyStimulus(16'd3, 16'd5, 16'd200, 16'd17);
        runOp(12 + EXTRA, -1, 1'b0, "cnt3", sum_cyc);
        checkOutput("cnt3_wsum_cyc", 32'(sum_cyc), 32'd9);
        checkOutput("cnt3_sum", 32'(res_val[0]), 32'd222);
        checkOutput("cnt3_max", 32'(res_val[1]), 32'd200);
        checkOutput("cnt3_min", 32'(res_val[2]), 32'd5);
        checkOutput("cnt3_sum_writes", 32'(res_cnt[0]), 32'd1);
        checkOutput("cnt3_ovf", 32'(ovf), 32'd0);
        checkOutput("cnt3_empty", 32'(empty), 32'd0);
        if (AVG_ON) checkOutput("cnt3_avg", 32'(res_val[3]), 32'd74);
        checkOutput("cnt3_avg_writes", 32'(res_cnt[3]), AVG_ON ? 32'd1 : 32'd0);
        @(negedge clock);
        checkOutput("cnt3_busy_after", 32'(busy), 32'd0);
        checkOutput("cnt3_done_after", 32'(done), 32'd0);

        // Count 0
        applyStimulus(16'd0, 16'd9, 16'd9, 16'd9);
        runOp(ZERO_DONE, -1, 1'b0, "cnt0", sum_cyc);
        checkOutput("cnt0_wsum_cyc", 32'(sum_cyc), 32'd3);
        checkOutput("cnt0_sum", 32'(res_val[0]), 32'd0);
        checkOutput("cnt0_max", 32'(res_val[1]), 32'd0);
        checkOutput("cnt0_min", 32'(res_val[2]), 32'd0);
        checkOutput("cnt0_empty", 32'(empty), 32'd1);
        if (AVG_ON) checkOutput("cnt0_avg", 32'(res_val[3]), 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("cnt0_empty_held", 32'(empty), 32'd1);

        // Count 2 with saturation
        applyStimulus(16'd2, 16'hF000, 16'h2000, 16'd0);
        runOp(10 + EXTRA, -1, 1'b0, "sat", sum_cyc);
        checkOutput("sat_sum", 32'(res_val[0]), 32'hFFFF);
        checkOutput("sat_max", 32'(res_val[1]), 32'hF000);
        checkOutput("sat_min", 32'(res_val[2]), 32'h2000);
        checkOutput("sat_ovf", 32'(ovf), 32'd1);
        checkOutput("sat_empty", 32'(empty), 32'd0);
        if (AVG_ON) checkOutput("sat_avg", 32'(res_val[3]), 32'h7FFF);

        // Count 100 clamps to 64; start pulses while busy
        applyStimulus(16'd100, 16'd1, 16'd2, 16'd3);
        for (int i = 3; i < 100; i++) img[16 + i] = 16'(i + 1);
        runOp(134 + EXTRA, -1, 1'b1, "clamp", sum_cyc);
        tcount = 0;
        for (int i = 16; i < 2048; i++) if (touched[i]) tcount++;
        checkOutput("clamp_reads", 32'(tcount), 32'd64);
        checkOutput("clamp_last_read", 32'(touched[79]), 32'd1);
        checkOutput("clamp_no_read80", 32'(touched[80]), 32'd0);
        checkOutput("clamp_sum", 32'(res_val[0]), 32'd2080);
        checkOutput("clamp_max", 32'(res_val[1]), 32'd64);
        checkOutput("clamp_min", 32'(res_val[2]), 32'd1);
        checkOutput("clamp_ovf", 32'(ovf), 32'd0);
        if (AVG_ON) checkOutput("clamp_avg", 32'(res_val[3]), 32'd32);
        repeat (3) @(negedge clock);
        checkOutput("clamp_idle_after", 32'(busy), 32'd0);

        // en low for 5 cycles during the first ACC
        applyStimulus(16'd3, 16'd5, 16'd200, 16'd17);
        runOp(17 + EXTRA, 4, 1'b0, "frz", sum_cyc);
        checkOutput("frz_wsum_cyc", 32'(sum_cyc), 32'd14);
        checkOutput("frz_sum", 32'(res_val[0]), 32'd222);
        checkOutput("frz_max", 32'(res_val[1]), 32'd200);
        checkOutput("frz_min", 32'(res_val[2]), 32'd5);

        // Reset during RD_DAT, then a clean run
        applyStimulus(16'd3, 16'd5, 16'd200, 16'd17);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("abort_pre_addr", 32'(address), 32'd16);
        nrst = 1'b0;
        #1;
        checkOutput("abort_address", 32'(address), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_data_out", 32'(data_out), 32'd0);
        checkOutput("abort_wr_en", 32'(wr_en), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clock);
        nrst = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("abort_no_wr", 32'(res_cnt[0] + res_cnt[1] + res_cnt[2] + res_cnt[3]), 32'd0);
        checkOutput("abort_no_stray", 32'(stray_wr), 32'd0);
        runOp(12 + EXTRA, -1, 1'b0, "rerun", sum_cyc);
        checkOutput("rerun_sum", 32'(res_val[0]), 32'd222);
        checkOutput("rerun_min", 32'(res_val[2]), 32'd5);

        $display("[TB] directed sequence complete");
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
